ama_riscv_bp_spec_ctrl: RTL and testbench

Speculation controller for the branch predictor. It records each branch prediction made in decode in a small in-order in-flight queue. When execute resolves the oldest entry, it checks the outcome against the recorded prediction, drives the predictor update strobes, and issues a multi-cycle front-end flush on a mispredict. It sits between the decode/execute pipeline control and ama_riscv_bp, and keeps saturating hit/miss counters for performance monitoring.

---
 rtl/ama_riscv_bp_spec_ctrl_pkg.sv | 41 ++++
 rtl/ama_riscv_bp_spec_ctrl_if.sv | 30 +++
 rtl/ama_riscv_bp_spec_fifo.sv | 52 +++++
 rtl/ama_riscv_bp_spec_ctrl.sv | 118 +++++++++++
 tb/tb_ama_riscv_bp_spec_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ama_riscv_bp_spec_ctrl_pkg.sv
// Shared types for the branch-predictor speculation controller: branch
// outcome encoding, component predictions, predictor pipe bundle, the
// controller FSM state and the in-flight queue entry.
package ama_riscv_bp_spec_ctrl_pkg;

    typedef enum logic {
        B_NT = 1'b0,
        B_T  = 1'b1
    } branch_t;

    // Component predictions feeding the combined predictor's meta update
    typedef struct packed {
        branch_t gshare;
        branch_t bimodal;
    } bp_comp_t;

    typedef struct packed {
        logic enter;
        logic resolve;
    } bp_spec_t;

    typedef struct packed {
        bp_spec_t    spec;
        branch_t     br_res;
        logic [31:0] pc_dec;
        logic [31:0] pc_exe;
    } bp_pipe_t;

    typedef enum logic {
        BPS_RUN   = 1'b0,
        BPS_FLUSH = 1'b1
    } bp_spec_state_t;

    typedef struct packed {
        branch_t  pred;
        bp_comp_t comp;
    } bp_spec_entry_t;

    localparam bp_comp_t BP_COMP_RST = '{gshare: B_NT, bimodal: B_NT};

endpackage

// File: rtl/ama_riscv_bp_spec_ctrl_if.sv
// Decode/execute handshake and predictor-facing signals of the speculation
// controller. The pipeline side is the master, the controller the slave.
interface ama_riscv_bp_spec_ctrl_if;
    import ama_riscv_bp_spec_ctrl_pkg::*;

    logic        dec_br;
    logic [31:0] dec_pc;
    branch_t     dec_pred;
    bp_comp_t    dec_comp;
    logic        exe_br;
    logic [31:0] exe_pc;
    branch_t     exe_res;

    bp_pipe_t    bp_pipe;
    bp_comp_t    bp_comp_pred;
    logic        stall_dec;
    logic        flush_fe;
    logic        mispred;

    modport master (
        output dec_br, dec_pc, dec_pred, dec_comp, exe_br, exe_pc, exe_res,
        input  bp_pipe, bp_comp_pred, stall_dec, flush_fe, mispred
    );

    modport slave (
        input  dec_br, dec_pc, dec_pred, dec_comp, exe_br, exe_pc, exe_res,
        output bp_pipe, bp_comp_pred, stall_dec, flush_fe, mispred
    );

endinterface

// File: rtl/ama_riscv_bp_spec_fifo.sv
// In-order queue of unresolved branch predictions. Pointers carry one extra
// wrap bit so full and empty are distinguishable; clear drops everything.
module ama_riscv_bp_spec_fifo
    import ama_riscv_bp_spec_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  bp_spec_entry_t wdata,
    input  logic           pop,
    input  logic           clear,
    output logic           full,
    output logic           empty,
    output bp_spec_entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);

    bp_spec_entry_t mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  occupancy;

    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (occupancy == PTR_DEPTH);
    assign empty     = (occupancy == '0);
    assign head      = mem[rd_ptr[AW-1:0]];

    // Entry storage; data only, no reset needed
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; clear (mispredict squash) wins over push/pop
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/ama_riscv_bp_spec_ctrl.sv
// Branch-predictor speculation controller: tracks in-flight predictions,
// checks them at execute, drives predictor update strobes, flushes the
// front end on a mispredict and counts hits/misses.
module ama_riscv_bp_spec_ctrl
    import ama_riscv_bp_spec_ctrl_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int FLUSH_CYC = 2,
    parameter int PERF_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    ama_riscv_bp_spec_ctrl_if.slave bus,
    output logic [PERF_BITS-1:0] cnt_hit,
    output logic [PERF_BITS-1:0] cnt_miss
);

    localparam int FCW = $clog2(FLUSH_CYC + 1);
    localparam logic [FCW-1:0]       FLUSH_LOAD = FCW'(FLUSH_CYC - 1);
    localparam logic [FCW-1:0]       FLUSH_ONE  = FCW'(1);
    localparam logic [PERF_BITS-1:0] PERF_ONE   = PERF_BITS'(1);

    bp_spec_state_t state;
    logic [FCW-1:0] flush_cnt;

    logic           full;
    logic           empty;
    bp_spec_entry_t head;
    bp_spec_entry_t wdata;
    logic           push;
    logic           pop;
    logic           hit;
    logic           miss;

    // A pop is checked against the head prediction in the same cycle; a
    // miss squashes any push this cycle because that branch is younger.
    // A push at full is accepted when the head leaves in the same cycle.
    assign pop   = bus.exe_br && !empty;
    assign hit   = pop && (head.pred == bus.exe_res);
    assign miss  = pop && (head.pred != bus.exe_res);
    assign push  = bus.dec_br && (!full || pop) && (state == BPS_RUN) && !miss;
    assign wdata = '{pred: bus.dec_pred, comp: bus.dec_comp};

    ama_riscv_bp_spec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .clear (miss),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Predictor strobes and side outputs, all combinational from the inputs
    always_comb begin
        bus.bp_pipe              = '0;
        bus.bp_comp_pred         = BP_COMP_RST;
        bus.bp_pipe.spec.enter   = push;
        bus.bp_pipe.spec.resolve = pop;
        if (push) begin
            bus.bp_pipe.pc_dec = bus.dec_pc;
            bus.bp_comp_pred   = bus.dec_comp;
        end
        if (pop) begin
            bus.bp_pipe.br_res = bus.exe_res;
            bus.bp_pipe.pc_exe = bus.exe_pc;
        end
    end

    assign bus.stall_dec = full;
    assign bus.mispred   = miss;
    assign bus.flush_fe  = (state == BPS_FLUSH);

    // RUN/FLUSH sequencing; flush held for FLUSH_CYC cycles after a miss
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BPS_RUN;
            flush_cnt <= '0;
        end else begin
            case (state)
                BPS_RUN: begin
                    if (miss) begin
                        state     <= BPS_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                BPS_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= BPS_RUN;
                    end else begin
                        flush_cnt <= flush_cnt - FLUSH_ONE;
                    end
                end
                default: state <= BPS_RUN;
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_hit  <= '0;
            cnt_miss <= '0;
        end else begin
            if (hit && (cnt_hit != '1))   cnt_hit  <= cnt_hit + PERF_ONE;
            if (miss && (cnt_miss != '1)) cnt_miss <= cnt_miss + PERF_ONE;
        end
    end

    // Execute should never resolve against an empty queue outside a flush
    a_exe_on_empty: assert property (@(posedge clk) disable iff (rst)
        !(bus.exe_br && empty && (state == BPS_RUN)));

endmodule

// File: tb/tb_ama_riscv_bp_spec_ctrl.sv
// Directed bench for the speculation controller (DEPTH=2, FLUSH_CYC=2,
// PERF_BITS=4 so counter saturation is reachable quickly).
module tb_ama_riscv_bp_spec_ctrl;
    import ama_riscv_bp_spec_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] cnt_hit;
    logic [3:0] cnt_miss;
    int nvec = 0;
    int nfail = 0;

    ama_riscv_bp_spec_ctrl_if bus ();

    ama_riscv_bp_spec_ctrl #(
        .DEPTH     (2),
        .FLUSH_CYC (2),
        .PERF_BITS (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .cnt_hit  (cnt_hit),
        .cnt_miss (cnt_miss)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.dec_br   = 1'b0;
        bus.dec_pc   = '0;
        bus.dec_pred = B_NT;
        bus.dec_comp = '{B_NT, B_NT};
        bus.exe_br   = 1'b0;
        bus.exe_pc   = '0;
        bus.exe_res  = B_NT;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic drive_push(input logic [31:0] pc, input branch_t p);
        bus.dec_br   = 1'b1;
        bus.dec_pc   = pc;
        bus.dec_pred = p;
        bus.dec_comp = '{p, B_NT};
    endtask

    task automatic drive_pop(input logic [31:0] pc, input branch_t r);
        bus.exe_br  = 1'b1;
        bus.exe_pc  = pc;
        bus.exe_res = r;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (bus.bp_pipe !== '0) begin nfail++; $display("FAIL reset_bp_pipe got %h exp 0", bus.bp_pipe); end
        nvec++; if (bus.bp_comp_pred !== 2'b00) begin nfail++; $display("FAIL reset_comp_pred got %b exp 00", bus.bp_comp_pred); end
        nvec++; if ({bus.stall_dec, bus.flush_fe, bus.mispred} !== 3'b000) begin nfail++; $display("FAIL reset_ctrl got %b exp 000", {bus.stall_dec, bus.flush_fe, bus.mispred}); end
        nvec++; if ({cnt_hit, cnt_miss} !== 8'h00) begin nfail++; $display("FAIL reset_counters got %h exp 00", {cnt_hit, cnt_miss}); end
    endtask

    task automatic test_fill_stall();
        do_reset();
        bus.dec_br = 1'b1; bus.dec_pc = 32'h100; bus.dec_pred = B_T; bus.dec_comp = '{B_T, B_NT};
        #1;
        nvec++; if (bus.bp_pipe.spec.enter !== 1'b1) begin nfail++; $display("FAIL fill_enter0 got %b exp 1", bus.bp_pipe.spec.enter); end
        nvec++; if (bus.bp_pipe.pc_dec !== 32'h100) begin nfail++; $display("FAIL fill_pc_dec got %h exp 100", bus.bp_pipe.pc_dec); end
        nvec++; if (bus.bp_comp_pred !== 2'b10) begin nfail++; $display("FAIL fill_comp_pred got %b exp 10", bus.bp_comp_pred); end
        cyc();
        drive_push(32'h104, B_NT);
        #1;
        nvec++; if (bus.bp_pipe.spec.enter !== 1'b1) begin nfail++; $display("FAIL fill_enter1 got %b exp 1", bus.bp_pipe.spec.enter); end
        cyc();
        drive_push(32'h108, B_T);
        #1;
        nvec++; if (bus.stall_dec !== 1'b1) begin nfail++; $display("FAIL fill_stall got %b exp 1", bus.stall_dec); end
        nvec++; if (bus.bp_pipe.spec.enter !== 1'b0) begin nfail++; $display("FAIL fill_enter2_suppressed got %b exp 0", bus.bp_pipe.spec.enter); end
        cyc();
        idle();
        drive_pop(32'h100, B_T);
        #1;
        nvec++; if (bus.bp_pipe.spec.resolve !== 1'b1) begin nfail++; $display("FAIL fill_resolve got %b exp 1", bus.bp_pipe.spec.resolve); end
        nvec++; if (bus.bp_pipe.pc_exe !== 32'h100 || bus.bp_pipe.br_res !== B_T) begin nfail++; $display("FAIL fill_res_fields got %h/%b exp 100/1", bus.bp_pipe.pc_exe, bus.bp_pipe.br_res); end
        nvec++; if (bus.mispred !== 1'b0) begin nfail++; $display("FAIL fill_mispred got %b exp 0", bus.mispred); end
        cyc();
        nvec++; if (cnt_hit !== 4'd1 || bus.stall_dec !== 1'b0) begin nfail++; $display("FAIL fill_after_pop got hit=%0d stall=%b exp hit=1 stall=0", cnt_hit, bus.stall_dec); end
        drive_pop(32'h104, B_NT);
        cyc();
        idle();
        nvec++; if (cnt_hit !== 4'd2 || cnt_miss !== 4'd0) begin nfail++; $display("FAIL fill_drain got hit=%0d miss=%0d exp 2/0", cnt_hit, cnt_miss); end
    endtask

    task automatic test_mispredict();
        do_reset();
        drive_push(32'h200, B_T);
        cyc();
        drive_push(32'h204, B_NT);
        cyc();
        idle();
        drive_pop(32'h200, B_NT);
        #1;
        nvec++; if ({bus.bp_pipe.spec.resolve, bus.mispred, bus.flush_fe} !== 3'b110) begin nfail++; $display("FAIL mis_detect got res/mis/flush=%b exp 110", {bus.bp_pipe.spec.resolve, bus.mispred, bus.flush_fe}); end
        cyc();
        drive_pop(32'h204, B_NT);
        drive_push(32'h300, B_T);
        #1;
        nvec++; if ({bus.flush_fe, bus.mispred} !== 2'b10) begin nfail++; $display("FAIL mis_flush1 got flush/mis=%b exp 10", {bus.flush_fe, bus.mispred}); end
        nvec++; if (cnt_miss !== 4'd1) begin nfail++; $display("FAIL mis_cnt_miss got %0d exp 1", cnt_miss); end
        nvec++; if ({bus.bp_pipe.spec.resolve, bus.bp_pipe.spec.enter} !== 2'b00) begin nfail++; $display("FAIL mis_flush_strobes got res/enter=%b exp 00", {bus.bp_pipe.spec.resolve, bus.bp_pipe.spec.enter}); end
        cyc();
        idle();
        #1;
        nvec++; if (bus.flush_fe !== 1'b1) begin nfail++; $display("FAIL mis_flush2 got %b exp 1", bus.flush_fe); end
        cyc();
        nvec++; if (bus.flush_fe !== 1'b0) begin nfail++; $display("FAIL mis_flush3 got %b exp 0", bus.flush_fe); end
        drive_push(32'h400, B_T);
        cyc();
        idle();
        drive_pop(32'h400, B_T);
        #1;
        nvec++; if (bus.mispred !== 1'b0) begin nfail++; $display("FAIL mis_discarded_head got mispred %b exp 0", bus.mispred); end
        cyc();
        idle();
        nvec++; if (cnt_hit !== 4'd1 || cnt_miss !== 4'd1) begin nfail++; $display("FAIL mis_counts got hit=%0d miss=%0d exp 1/1", cnt_hit, cnt_miss); end
    endtask

    task automatic test_back_to_back();
        branch_t p [10];
        for (int k = 0; k < 10; k++) p[k] = (k % 2 == 0) ? B_T : B_NT;
        do_reset();
        drive_push(32'h1000, p[0]);
        cyc();
        drive_push(32'h1004, p[1]);
        cyc();
        for (int i = 0; i < 8; i++) begin
            drive_push(32'h1000 + 32'(4 * (i + 2)), p[i + 2]);
            drive_pop(32'h1000 + 32'(4 * i), p[i]);
            #1;
            nvec++; if ({bus.bp_pipe.spec.enter, bus.bp_pipe.spec.resolve, bus.mispred, bus.stall_dec} !== 4'b1101) begin nfail++; $display("FAIL b2b_cycle%0d got enter/res/mis/stall=%b exp 1101", i, {bus.bp_pipe.spec.enter, bus.bp_pipe.spec.resolve, bus.mispred, bus.stall_dec}); end
            cyc();
        end
        idle();
        drive_pop(32'h1020, p[8]);
        cyc();
        drive_pop(32'h1024, p[9]);
        cyc();
        idle();
        nvec++; if (cnt_hit !== 4'd10 || cnt_miss !== 4'd0) begin nfail++; $display("FAIL b2b_counts got hit=%0d miss=%0d exp 10/0", cnt_hit, cnt_miss); end
        nvec++; if (bus.stall_dec !== 1'b0) begin nfail++; $display("FAIL b2b_drained_stall got %b exp 0", bus.stall_dec); end
    endtask

    task automatic test_mispred_with_push();
        do_reset();
        drive_push(32'h500, B_T);
        cyc();
        drive_pop(32'h500, B_NT);
        drive_push(32'h504, B_T);
        #1;
        nvec++; if ({bus.bp_pipe.spec.enter, bus.bp_pipe.spec.resolve, bus.mispred} !== 3'b011) begin nfail++; $display("FAIL mwp_strobes got enter/res/mis=%b exp 011", {bus.bp_pipe.spec.enter, bus.bp_pipe.spec.resolve, bus.mispred}); end
        cyc();
        idle();
        cyc();
        cyc();
        nvec++; if (bus.flush_fe !== 1'b0) begin nfail++; $display("FAIL mwp_flush_done got %b exp 0", bus.flush_fe); end
        drive_push(32'h600, B_NT);
        cyc();
        idle();
        drive_pop(32'h600, B_NT);
        #1;
        nvec++; if (bus.mispred !== 1'b0) begin nfail++; $display("FAIL mwp_queue_empty got mispred %b exp 0", bus.mispred); end
        cyc();
        idle();
        nvec++; if (cnt_hit !== 4'd1 || cnt_miss !== 4'd1) begin nfail++; $display("FAIL mwp_counts got hit=%0d miss=%0d exp 1/1", cnt_hit, cnt_miss); end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        drive_push(32'h700, B_T);
        cyc();
        idle();
        drive_pop(32'h700, B_NT);
        cyc();
        idle();
        nvec++; if (bus.flush_fe !== 1'b1) begin nfail++; $display("FAIL rmf_in_flush got %b exp 1", bus.flush_fe); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        nvec++; if ({bus.flush_fe, bus.mispred} !== 2'b00) begin nfail++; $display("FAIL rmf_flush_abort got flush/mis=%b exp 00", {bus.flush_fe, bus.mispred}); end
        nvec++; if ({cnt_hit, cnt_miss} !== 8'h00) begin nfail++; $display("FAIL rmf_counters got %h exp 00", {cnt_hit, cnt_miss}); end
        drive_push(32'h800, B_T);
        #1;
        nvec++; if (bus.bp_pipe.spec.enter !== 1'b1) begin nfail++; $display("FAIL rmf_push got %b exp 1", bus.bp_pipe.spec.enter); end
        cyc();
        idle();
        drive_pop(32'h800, B_T);
        #1;
        nvec++; if ({bus.bp_pipe.spec.resolve, bus.mispred} !== 2'b10) begin nfail++; $display("FAIL rmf_pop got res/mis=%b exp 10", {bus.bp_pipe.spec.resolve, bus.mispred}); end
        cyc();
        idle();
        nvec++; if (cnt_hit !== 4'd1) begin nfail++; $display("FAIL rmf_hit got %0d exp 1", cnt_hit); end
    endtask

    task automatic test_hit_saturate();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_push(32'h900, B_T);
            cyc();
            idle();
            drive_pop(32'h900, B_T);
            cyc();
            idle();
            if (i == 14) begin
                nvec++; if (cnt_hit !== 4'd15) begin nfail++; $display("FAIL sat_reach got %0d exp 15", cnt_hit); end
            end
        end
        nvec++; if (cnt_hit !== 4'd15 || cnt_miss !== 4'd0) begin nfail++; $display("FAIL sat_hold got hit=%0d miss=%0d exp 15/0", cnt_hit, cnt_miss); end
    endtask

    initial begin
        idle();
        test_reset();
        test_fill_stall();
        test_mispredict();
        test_back_to_back();
        test_mispred_with_push();
        test_reset_mid_flush();
        test_hit_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
